// File: rtl/ped_pkg.sv
// Shared encodings, timing defaults and light-legality helper for the pedestrian signal controller.
// Optional flash phase is enabled by defining PED_FLASH_EN.
package ped_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_WALK  = 2'b01,
        ST_FLASH = 2'b10
    } ped_state_e;

    localparam logic [7:0] WALK_TIME_DEF  = 8'd10;
    localparam logic [7:0] FLASH_TIME_DEF = 8'd4;

    function automatic logic one_hot3(input logic g, input logic y, input logic r);
        return (g & ~y & ~r) | (~g & y & ~r) | (~g & ~y & r);
    endfunction

endpackage

// File: rtl/ped_axis_fsm.sv
// One pedestrian axis: request latch, green-rise detect, phase down-counter and lamp decode.
// PED_FLASH_EN adds the flashing DON'T-WALK phase between WALK and IDLE.
module ped_axis_fsm
    import ped_pkg::*;
#(
    parameter logic [7:0] WALK_TIME  = WALK_TIME_DEF,
    parameter logic [7:0] FLASH_TIME = FLASH_TIME_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       g,
    input  logic       y,
    input  logic       btn,
    input  logic       force_idle,
    output logic       walk,
    output logic       dont_walk,
    output logic       req_pending,
    output logic [7:0] cnt
);

`ifdef PED_FLASH_EN
    localparam ped_state_e WALK_EXIT_ST  = ST_FLASH;
    localparam logic [7:0] WALK_EXIT_CNT = FLASH_TIME;
`else
    // Without the flash phase WALK ends straight in IDLE; FLASH_TIME has no effect.
    localparam ped_state_e WALK_EXIT_ST  = ST_IDLE;
    localparam logic [7:0] WALK_EXIT_CNT = FLASH_TIME & 8'h00;
`endif

    ped_state_e state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       req_q, req_d;
    logic       g_prev_q, g_prev_d;
    logic       green_rise;
    logic       abort;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= 8'd0;
            req_q    <= 1'b0;
            g_prev_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            req_q    <= req_d;
            g_prev_q <= g_prev_d;
        end
    end

    assign green_rise = g & ~g_prev_q;
    assign abort      = ~g | y;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        req_d    = req_q;
        g_prev_d = g;
        if (force_idle) begin
            state_d = ST_IDLE;
            cnt_d   = 8'd0;
            req_d   = req_q | btn;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    cnt_d = 8'd0;
                    if (green_rise && (req_q || btn)) begin
                        state_d = ST_WALK;
                        cnt_d   = WALK_TIME;
                        req_d   = 1'b0;
                    end else begin
                        req_d = req_q | btn;
                    end
                end
                ST_WALK: begin
                    // Buttons are deliberately not latched while walking.
                    if (abort) begin
                        state_d = ST_IDLE;
                        cnt_d   = 8'd0;
                    end else if (cnt_q <= 8'd1) begin
                        state_d = WALK_EXIT_ST;
                        cnt_d   = WALK_EXIT_CNT;
                    end else begin
                        cnt_d = cnt_q - 8'd1;
                    end
                end
`ifdef PED_FLASH_EN
                ST_FLASH: begin
                    req_d = req_q | btn;
                    if (abort || cnt_q <= 8'd1) begin
                        state_d = ST_IDLE;
                        cnt_d   = 8'd0;
                    end else begin
                        cnt_d = cnt_q - 8'd1;
                    end
                end
`endif
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = 8'd0;
                end
            endcase
        end
    end

    always_comb begin
        walk      = 1'b0;
        dont_walk = 1'b1;
        cnt       = 8'd0;
        if (!force_idle) begin
            case (state_q)
                ST_WALK: begin
                    walk      = 1'b1;
                    dont_walk = 1'b0;
                    cnt       = cnt_q;
                end
`ifdef PED_FLASH_EN
                ST_FLASH: begin
                    // First flash cycle holds FLASH_TIME, so matching parity means lamp on.
                    dont_walk = (cnt_q[0] == FLASH_TIME[0]);
                    cnt       = cnt_q;
                end
`endif
                default: begin
                    walk      = 1'b0;
                    dont_walk = 1'b1;
                end
            endcase
        end
    end

    assign req_pending = req_q;

endmodule

// File: rtl/ped_signal_ctrl.sv
// Pedestrian signal controller: two independent axis FSMs plus sticky illegal-light fault.
// Define PED_FLASH_EN to include the flashing DON'T-WALK phase.
module ped_signal_ctrl
    import ped_pkg::*;
#(
    parameter logic [7:0] WALK_TIME  = WALK_TIME_DEF,
    parameter logic [7:0] FLASH_TIME = FLASH_TIME_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ns_g,
    input  logic       ns_y,
    input  logic       ns_r,
    input  logic       ew_g,
    input  logic       ew_y,
    input  logic       ew_r,
    input  logic       ns_btn,
    input  logic       ew_btn,
    output logic       ns_walk,
    output logic       ns_dont_walk,
    output logic       ew_walk,
    output logic       ew_dont_walk,
    output logic       ns_req_pending,
    output logic       ew_req_pending,
    output logic [7:0] ns_cnt,
    output logic [7:0] ew_cnt,
    output logic       fault
);

    logic fault_q, fault_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fault_q <= 1'b0;
        end else begin
            fault_q <= fault_d;
        end
    end

    always_comb begin
        fault_d = fault_q
                | (ns_g & ew_g)
                | ~one_hot3(ns_g, ns_y, ns_r)
                | ~one_hot3(ew_g, ew_y, ew_r);
    end

    assign fault = fault_q;

    ped_axis_fsm #(
        .WALK_TIME  (WALK_TIME),
        .FLASH_TIME (FLASH_TIME)
    ) u_ns (
        .clk         (clk),
        .rst_n       (rst_n),
        .g           (ns_g),
        .y           (ns_y),
        .btn         (ns_btn),
        .force_idle  (fault_q),
        .walk        (ns_walk),
        .dont_walk   (ns_dont_walk),
        .req_pending (ns_req_pending),
        .cnt         (ns_cnt)
    );

    ped_axis_fsm #(
        .WALK_TIME  (WALK_TIME),
        .FLASH_TIME (FLASH_TIME)
    ) u_ew (
        .clk         (clk),
        .rst_n       (rst_n),
        .g           (ew_g),
        .y           (ew_y),
        .btn         (ew_btn),
        .force_idle  (fault_q),
        .walk        (ew_walk),
        .dont_walk   (ew_dont_walk),
        .req_pending (ew_req_pending),
        .cnt         (ew_cnt)
    );

endmodule

// File: tb/tb_ped_signal_ctrl.sv
// Randomized traffic/button stimulus checked against a phase-elapsed reference model.
module tb_ped_signal_ctrl;

    localparam int WALK_CYC = 10;
`ifdef PED_FLASH_EN
    localparam int FLASH_CYC = 4;
`else
    localparam int FLASH_CYC = 0;
`endif

    localparam logic [5:0] L_NSG = 6'b100_001;
    localparam logic [5:0] L_NSY = 6'b010_001;
    localparam logic [5:0] L_RED = 6'b001_001;
    localparam logic [5:0] L_EWG = 6'b001_100;
    localparam logic [5:0] L_EWY = 6'b001_010;

    localparam int M_IDLE  = 0;
    localparam int M_WALK  = 1;
    localparam int M_FLASH = 2;

    logic       clk;
    logic       rst_n;
    logic       ns_g, ns_y, ns_r, ew_g, ew_y, ew_r;
    logic       ns_btn, ew_btn;
    logic       ns_walk, ns_dont_walk, ew_walk, ew_dont_walk;
    logic       ns_req_pending, ew_req_pending;
    logic [7:0] ns_cnt, ew_cnt;
    logic       fault;

    int n_checks = 0;
    int n_fail   = 0;
    int n_walks  = 0;

    int mmode[2];
    int mel[2];
    bit mpend[2];
    bit mprev[2];
    bit mfault;

    ped_signal_ctrl dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ns_g           (ns_g),
        .ns_y           (ns_y),
        .ns_r           (ns_r),
        .ew_g           (ew_g),
        .ew_y           (ew_y),
        .ew_r           (ew_r),
        .ns_btn         (ns_btn),
        .ew_btn         (ew_btn),
        .ns_walk        (ns_walk),
        .ns_dont_walk   (ns_dont_walk),
        .ew_walk        (ew_walk),
        .ew_dont_walk   (ew_dont_walk),
        .ns_req_pending (ns_req_pending),
        .ew_req_pending (ew_req_pending),
        .ns_cnt         (ns_cnt),
        .ew_cnt         (ew_cnt),
        .fault          (fault)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int a = 0; a < 2; a++) begin
            mmode[a] = M_IDLE;
            mel[a]   = 0;
            mpend[a] = 1'b0;
            mprev[a] = 1'b0;
        end
        mfault = 1'b0;
    endtask

    function automatic bit legal_axis(input logic g, input logic y, input logic r);
        int n;
        n = int'(g) + int'(y) + int'(r);
        return n == 1;
    endfunction

    task automatic model_step();
        bit g[2], y[2], b[2];
        bit nf;
        bit rise;
        g[0] = ns_g; y[0] = ns_y; b[0] = ns_btn;
        g[1] = ew_g; y[1] = ew_y; b[1] = ew_btn;
        nf = mfault || (ns_g && ew_g) || !legal_axis(ns_g, ns_y, ns_r)
                    || !legal_axis(ew_g, ew_y, ew_r);
        for (int a = 0; a < 2; a++) begin
            rise = g[a] && !mprev[a];
            if (mfault) begin
                mpend[a] = mpend[a] | b[a];
                mmode[a] = M_IDLE;
                mel[a]   = 0;
            end else if (mmode[a] == M_IDLE) begin
                if (rise && (mpend[a] || b[a])) begin
                    mmode[a] = M_WALK;
                    mel[a]   = 0;
                    mpend[a] = 1'b0;
                    n_walks++;
                end else begin
                    mpend[a] = mpend[a] | b[a];
                end
            end else if (mmode[a] == M_WALK) begin
                if (!g[a] || y[a]) begin
                    mmode[a] = M_IDLE;
                    mel[a]   = 0;
                end else begin
                    mel[a]++;
                    if (mel[a] == WALK_CYC) begin
                        mmode[a] = (FLASH_CYC > 0) ? M_FLASH : M_IDLE;
                        mel[a]   = 0;
                    end
                end
            end else begin
                mpend[a] = mpend[a] | b[a];
                if (!g[a] || y[a]) begin
                    mmode[a] = M_IDLE;
                    mel[a]   = 0;
                end else begin
                    mel[a]++;
                    if (mel[a] == FLASH_CYC) begin
                        mmode[a] = M_IDLE;
                        mel[a]   = 0;
                    end
                end
            end
            mprev[a] = g[a];
        end
        mfault = nf;
    endtask

    task automatic check_all();
        string nm;
        bit    e_walk, e_dw;
        int    e_cnt;
        for (int a = 0; a < 2; a++) begin
            nm = (a == 0) ? "ns" : "ew";
            e_walk = !mfault && (mmode[a] == M_WALK);
            e_dw   = mfault || (mmode[a] == M_IDLE) || (mmode[a] == M_FLASH && (mel[a] % 2) == 0);
            if (mfault || mmode[a] == M_IDLE) e_cnt = 0;
            else if (mmode[a] == M_WALK)      e_cnt = WALK_CYC - mel[a];
            else                              e_cnt = FLASH_CYC - mel[a];
            chk({nm, "_walk"},      32'((a == 0) ? ns_walk : ew_walk), 32'(e_walk));
            chk({nm, "_dont_walk"}, 32'((a == 0) ? ns_dont_walk : ew_dont_walk), 32'(e_dw));
            chk({nm, "_cnt"},       32'((a == 0) ? ns_cnt : ew_cnt), 32'(e_cnt));
            chk({nm, "_req"},       32'((a == 0) ? ns_req_pending : ew_req_pending), 32'(mpend[a]));
        end
        chk("fault", 32'(fault), 32'(mfault));
    endtask

    task automatic cycle(input logic [5:0] lights, input int pct);
        @(negedge clk);
        check_all();
        {ns_g, ns_y, ns_r, ew_g, ew_y, ew_r} = lights;
        ns_btn = ($urandom_range(99) < pct);
        ew_btn = ($urandom_range(99) < pct);
        @(posedge clk);
        model_step();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        model_step();
    endtask

    task automatic run_round(input int pct);
        int  len;
        bit  mid_rst;
        mid_rst = ($urandom_range(7) == 0);
        len = $urandom_range(3, 30);
        for (int i = 0; i < len; i++) begin
            cycle(L_NSG, pct);
            if (mid_rst && i == len / 2) do_reset();
        end
        if ($urandom_range(3) != 0)
            for (int i = 0; i < 3; i++) cycle(L_NSY, pct);
        cycle(L_RED, pct);
        len = $urandom_range(3, 30);
        for (int i = 0; i < len; i++) cycle(L_EWG, pct);
        if ($urandom_range(3) != 0)
            for (int i = 0; i < 3; i++) cycle(L_EWY, pct);
        cycle(L_RED, pct);
    endtask

    initial begin
        int pct;
        rst_n = 1'b0;
        {ns_g, ns_y, ns_r, ew_g, ew_y, ew_r} = L_RED;
        ns_btn = 1'b0;
        ew_btn = 1'b0;
        model_reset();
        #2;
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        model_step();

        for (int r = 0; r < 40; r++) begin
            case ($urandom_range(2))
                0: pct = 0;
                1: pct = 5;
                default: pct = 30;
            endcase
            run_round(pct);
        end

        cycle(6'b100_100, 10);
        for (int i = 0; i < 12; i++) cycle(L_NSG, 20);
        do_reset();
        for (int r = 0; r < 4; r++) run_round(10);

        cycle(6'b110_001, 10);
        for (int i = 0; i < 8; i++) cycle(L_EWG, 20);
        do_reset();
        for (int r = 0; r < 4; r++) run_round(10);

        @(negedge clk);
        check_all();
        $display("walk phases entered: %0d", n_walks);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ped_signal_ctrl.md
PED_SIGNAL_CTRL -- requirements
Module: ped_signal_ctrl

Interface
REQ-001 Parameter WALK_TIME, default 8'd10, meaning steady-WALK duration in clk cycles, range 1..255.
REQ-002 Parameter FLASH_TIME, default 8'd4, meaning flashing-DON'T-WALK duration in clk cycles, range 1..255.
REQ-003 Port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 Port rst_n  input  1  asynchronous, active-low reset.
REQ-005 Ports ns_g, ns_y, ns_r, ew_g, ew_y, ew_r  input  1 each  vehicle light outputs of the upstream traffic_light block.
REQ-006 Ports ns_btn, ew_btn  input  1 each  synchronous pedestrian push-button, level or pulse.
REQ-007 Ports ns_walk, ns_dont_walk, ew_walk, ew_dont_walk  output  1 each  pedestrian lamp drives.
REQ-008 Ports ns_req_pending, ew_req_pending  output  1 each  latched, not-yet-served request.
REQ-009 Ports ns_cnt, ew_cnt  output  8 each  cycles remaining in current WALK/FLASH phase, 0 in IDLE.
REQ-010 Port fault  output  1  illegal light combination detected.

Function
REQ-011 Each axis (ns, ew) SHALL run an independent Moore FSM with states IDLE, WALK, FLASH; outputs decode from state only.
REQ-012 IDLE: walk=0, dont_walk=1; WALK: walk=1, dont_walk=0; FLASH: walk=0, dont_walk toggles every cycle, starting at 1.
REQ-013 Request latch SHALL set on any edge where btn=1 and state is IDLE or FLASH; btn during WALK SHALL be ignored.
REQ-014 Green rise SHALL be detected as axis_g=1 with registered previous axis_g=0.
REQ-015 IDLE->WALK on the edge where green rise and (req_pending or btn) both hold; req_pending clears on that same edge.
REQ-016 WALK SHALL last exactly WALK_TIME cycles; cnt loads WALK_TIME on entry and decrements by 1 per cycle.
REQ-017 WALK->FLASH when cnt reaches 1; FLASH lasts exactly FLASH_TIME cycles; FLASH->IDLE when cnt reaches 1.
REQ-018 Green falling, or axis_y=1, during WALK or FLASH SHALL force IDLE on the next edge, cnt=0 (safety abort).
REQ-019 A request arriving after green rise SHALL wait for the next green rise of that axis.
REQ-020 fault SHALL assert one cycle after ns_g&ew_g, or any axis with not exactly one of g/y/r set; while fault=1 both axes forced IDLE, walk=0, dont_walk=1.
REQ-021 fault SHALL be sticky until reset; request latches keep capturing during fault.
REQ-022 Counters SHALL be 8-bit unsigned; no wrap below 0, held at 0 in IDLE.

Reset
REQ-023 rst_n=0 SHALL asynchronously set both FSMs to IDLE, cnt=0, req_pending=0, fault=0, previous-green registers=0.
REQ-024 Outputs under reset: walk=0, dont_walk=1 both axes; reset mid-WALK discards the phase and pending request.
REQ-025 Deassertion of rst_n SHALL take effect on the next clk rising edge.

Configuration
REQ-026 Macro PED_FLASH_EN defined: FLASH state present per REQ-012/017.
REQ-027 PED_FLASH_EN undefined: no FLASH state; WALK->IDLE when cnt reaches 1; FLASH_TIME ignored; btn during WALK still ignored.

Structure
REQ-028 Shared package ped_pkg SHALL hold state encodings (IDLE=2'b00, WALK=2'b01, FLASH=2'b10) and default timing constants.
REQ-029 Sub-module ped_axis_fsm (FSM, request latch, counter, edge detect) SHALL be instantiated twice; top holds fault logic.

Verification
REQ-030 ns_btn pulse during ew_g, then ns_g rises -> ns_walk=1 for 10 cycles, ns_dont_walk toggles 4 cycles, then IDLE; ns_req_pending 1->0 at WALK entry.
REQ-031 No button, full traffic cycle -> ns_walk and ew_walk stay 0, dont_walk stay 1.
REQ-032 ns_btn held through WALK, no further press -> no second WALK on next ns_g rise.
REQ-033 ns_g drops at WALK cycle 5 -> next edge IDLE, ns_cnt=0.
REQ-034 Force ns_g=ew_g=1 -> fault=1 next cycle, all walk=0 until rst_n pulse.
REQ-035 rst_n low mid-FLASH -> immediate IDLE, cnt=0, req_pending=0; rebuild without PED_FLASH_EN -> WALK 10 cycles then IDLE.
